// File: rtl/ascon_perm_core.sv
// ascon_perm_core: Ascon-p permutation engine that applies 1..12 rounds to a 320-bit state,
//   computing UNROLL rounds per clock, with a start/busy/done handshake.
// Ports: clk, rst_n (async, active low); load/state_in capture; start/rounds launch;
//   busy/done/err status; state_out parallel result; rd_en/rd_data/rd_valid/rd_last serial readout.
module ascon_perm_core #(
  parameter int UNROLL = 1,
  parameter int OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [319:0]     state_in,
  input  logic             start,
  input  logic [3:0]       rounds,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [319:0]     state_out,
  input  logic             rd_en,
  output logic [OUT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_last
);

  localparam int            NW       = 320 / OUT_W;
  localparam int            PW       = $clog2(NW);
  localparam logic [PW-1:0] LAST_PTR = PW'(NW - 1);
  localparam logic [3:0]    STEP     = 4'(UNROLL);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_fsm;
  state_t           w_fsm_nxt;
  logic [319:0]     r_state;
  logic [3:0]       r_idx;
  logic [PW-1:0]    r_ptr;
  logic [OUT_W-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_err;

  logic [319:0]     w_rounds_out;
  logic [3:0]       w_idx_nxt;
  logic             w_run_last;
  logic             w_accept;
  logic             w_rounds_ok;
  logic             w_go;
  logic             w_rej;
  logic             w_rd_adv;
  logic [PW-1:0]    w_ptr_nxt;
  logic [OUT_W-1:0] w_rd_word;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One Ascon round: constant addition, bitsliced 5-bit S-box, linear diffusion.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [3:0]  hi;
    {x0, x1, x2, x3, x4} = s;
    hi = 4'hF - i;
    x2 = x2 ^ {56'd0, hi, i};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // Chain UNROLL rounds combinationally, indices r_idx, r_idx+1, ...
  always_comb begin
    w_rounds_out = r_state;
    for (int k = 0; k < UNROLL; k++) begin
      w_rounds_out = ascon_round(w_rounds_out, r_idx + 4'(k));
    end
  end

  assign w_idx_nxt  = r_idx + STEP;
  assign w_run_last = (w_idx_nxt >= 4'd12);

  // The DONE cycle accepts commands exactly like IDLE so back-to-back starts lose no cycle.
  assign w_accept    = (r_fsm != S_RUN);
  assign w_rounds_ok = (rounds >= 4'd1) && (rounds <= 4'd12) && ((int'(rounds) % UNROLL) == 0);
  assign w_go        = w_accept && !load && start && w_rounds_ok;
  assign w_rej       = w_accept && !load && start && !w_rounds_ok;
  assign w_rd_adv    = w_accept && !load && !w_go && rd_en && r_rd_valid;

  assign w_ptr_nxt = (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;
  assign w_rd_word = r_state[319 - OUT_W * int'(w_ptr_nxt) -: OUT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE, S_DONE: w_fsm_nxt = w_go ? S_RUN : S_IDLE;
      S_RUN:          if (w_run_last) w_fsm_nxt = S_DONE;
      default:        w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= '0;
      r_idx      <= '0;
      r_ptr      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_rej;
      if (r_fsm == S_RUN) begin
        r_state <= w_rounds_out;
        r_idx   <= w_idx_nxt;
        // Readout is primed on entry to DONE, so word 0 is visible alongside done.
        if (w_run_last) begin
          r_ptr      <= '0;
          r_rd_data  <= w_rounds_out[319 -: OUT_W];
          r_rd_valid <= 1'b1;
        end
      end else if (load) begin
        r_state    <= state_in;
        r_rd_valid <= 1'b0;
      end else if (w_go) begin
        r_idx      <= 4'd12 - rounds;
        r_rd_valid <= 1'b0;
      end else if (w_rd_adv) begin
        r_ptr     <= w_ptr_nxt;
        r_rd_data <= w_rd_word;
      end
    end
  end

  assign busy      = (r_fsm == S_RUN);
  assign done      = (r_fsm == S_DONE);
  assign err       = r_err;
  assign state_out = r_state;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_valid && (r_ptr == LAST_PTR);

endmodule
